// File: rtl/axi4_video_pattern_gen_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator.
//   pattern_t   : per-frame pattern selection
//   BAR_RGB     : colour-bar table, one bit per component, {R,G,B}
//   tdata_width : stream data width, whole bytes holding PX_PER_CLK RGB pixels
package axi4_video_pattern_gen_pkg;

  typedef enum logic [1:0] {
    COLOR_BARS = 2'd0,
    RAMP       = 2'd1,
    CHECKER    = 2'd2,
    SOLID      = 2'd3
  } pattern_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic int unsigned tdata_width(input int unsigned px_width,
                                              input int unsigned px_per_clk);
    return ((3 * px_width * px_per_clk + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Raster position counters for the pattern generator.
// x counts beats along a line (active beats then blanking beats), y counts lines.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   stall_i         : hold the counters at the current position
//   x_o, y_o        : position of the beat to be generated next
//   active_o        : position lies in the active picture
//   sof_o, eol_o    : first beat of the frame / last active beat of a line
//   frame_wrap_o    : counters step from the last position back to (0,0) this clock
module video_timing_cnt
  import axi4_video_pattern_gen_pkg::*;
#(
  parameter int unsigned X_ACT_BEATS = 1920,
  parameter int unsigned X_TOTAL     = 2200,
  parameter int unsigned Y_ACTIVE    = 1080,
  parameter int unsigned Y_TOTAL     = 1125,
  parameter int unsigned XW          = 12,
  parameter int unsigned YW          = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          active_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          frame_wrap_o
);

  localparam logic [XW-1:0] XLast = XW'(X_TOTAL - 1);
  localparam logic [XW-1:0] XAct  = XW'(X_ACT_BEATS);
  localparam logic [XW-1:0] XEol  = XW'(X_ACT_BEATS - 1);
  localparam logic [YW-1:0] YLast = YW'(Y_TOTAL - 1);
  localparam logic [YW-1:0] YAct  = YW'(Y_ACTIVE);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_end;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    line_end     = (x_q == XLast);
    frame_wrap_o = line_end && (y_q == YLast) && !stall_i;
    if (!stall_i) begin
      if (line_end) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign active_o = (x_q < XAct) && (y_q < YAct);
  assign sof_o    = (x_q == '0) && (y_q == '0);
  assign eol_o    = (x_q == XEol) && (y_q < YAct);

endmodule

// File: rtl/axi4_video_pattern_gen_mp.sv
// AXI4-Stream RGB test-pattern source, PX_PER_CLK pixels per beat, honours backpressure.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   pattern_i       : 0 colour bars, 1 moving ramp, 2 checkerboard, 3 solid (per frame)
//   solid_i         : solid colour {R,G,B}
//   video_o_t*      : AXI4-Stream master; tuser marks SOF, tlast marks end of active line
// The output register holds the beat on the bus; the counters point at the beat to build
// next, and only move when that register is free (empty, blanking, or handshaking).
module axi4_video_pattern_gen_mp
  import axi4_video_pattern_gen_pkg::*;
#(
  parameter int unsigned  Y_ACTIVE    = 1080,
  parameter int unsigned  Y_BLANKING  = 45,
  parameter int unsigned  X_ACTIVE    = 1920,
  parameter int unsigned  X_BLANKING  = 280,
  parameter int unsigned  PX_WIDTH    = 8,
  parameter int unsigned  PX_PER_CLK  = 1,
  parameter int unsigned  CHECK_LOG2  = 6,
  localparam int unsigned TDATA_WIDTH = tdata_width(PX_WIDTH, PX_PER_CLK)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             pattern_i,
  input  logic [3*PX_WIDTH-1:0]  solid_i,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic                   video_o_tlast,
  output logic                   video_o_tuser
);

  localparam int unsigned XActBeats = X_ACTIVE / PX_PER_CLK;
  localparam int unsigned XTotal    = XActBeats + X_BLANKING;
  localparam int unsigned YTotal    = Y_ACTIVE + Y_BLANKING;
  localparam int unsigned XW        = $clog2(XTotal + 1);
  localparam int unsigned YW        = $clog2(YTotal + 1);
  localparam int unsigned PxBits    = 3 * PX_WIDTH;
  localparam int unsigned BarPx     = X_ACTIVE / 8;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active, sof, eol, frame_wrap, stall;

  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d, pixels;
  pattern_t               pattern_q, pattern_d, pattern_cur;
  logic [PxBits-1:0]      solid_q, solid_d, solid_cur;
  logic [PX_WIDTH-1:0]    frame_cnt_q, frame_cnt_d, ramp;
  logic [31:0]            px;
  logic [2:0]             bar, rgb;
  logic                   chk, y_chk;

  // Only a presented active beat can be refused; blanking beats never assert tvalid.
  assign stall = tvalid_q && !video_o_tready;

  video_timing_cnt #(
    .X_ACT_BEATS(XActBeats),
    .X_TOTAL    (XTotal),
    .Y_ACTIVE   (Y_ACTIVE),
    .Y_TOTAL    (YTotal),
    .XW         (XW),
    .YW         (YW)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall),
    .x_o         (x),
    .y_o         (y),
    .active_o    (active),
    .sof_o       (sof),
    .eol_o       (eol),
    .frame_wrap_o(frame_wrap)
  );

  // The SOF beat is built straight from the inputs, which are latched for the rest of the frame.
  assign pattern_cur = sof ? pattern_t'(pattern_i) : pattern_q;
  assign solid_cur   = sof ? solid_i : solid_q;
  assign y_chk       = |((32'(y) >> CHECK_LOG2) & 32'd1);

  always_comb begin
    pixels = '0;
    px     = '0;
    bar    = '0;
    rgb    = '0;
    ramp   = '0;
    chk    = 1'b0;
    for (int p = 0; p < int'(PX_PER_CLK); p++) begin
      px   = 32'(x) * PX_PER_CLK + 32'(p);
      bar  = 3'(px / BarPx);
      rgb  = BAR_RGB[bar];
      ramp = PX_WIDTH'(px) + frame_cnt_q;
      chk  = px[CHECK_LOG2] ^ y_chk;
      unique case (pattern_cur)
        COLOR_BARS: pixels[p*PxBits +: PxBits] =
            {{PX_WIDTH{rgb[2]}}, {PX_WIDTH{rgb[1]}}, {PX_WIDTH{rgb[0]}}};
        RAMP:       pixels[p*PxBits +: PxBits] = {3{ramp}};
        CHECKER:    pixels[p*PxBits +: PxBits] = {PxBits{chk}};
        SOLID:      pixels[p*PxBits +: PxBits] = solid_cur;
        default:    ;
      endcase
    end
  end

  always_comb begin
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    pattern_d   = pattern_q;
    solid_d     = solid_q;
    frame_cnt_d = frame_cnt_q;
    if (!stall) begin
      tvalid_d = active;
      tdata_d  = active ? pixels : '0;
      tlast_d  = active && eol;
      tuser_d  = active && sof;
      if (sof) begin
        pattern_d = pattern_cur;
        solid_d   = solid_cur;
      end
    end
    if (frame_wrap) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      pattern_q   <= COLOR_BARS;
      solid_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      pattern_q   <= pattern_d;
      solid_q     <= solid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign video_o_tdata  = tdata_q;
  assign video_o_tvalid = tvalid_q;
  assign video_o_tlast  = tlast_q;
  assign video_o_tuser  = tuser_q;

endmodule

// File: tb/tb_axi4_video_pattern_gen_mp.sv
// Directed bench: DUT A is 16x4 active (2 px/beat, 12-beat line, 6-line frame),
// DUT B is 16x8 active (1 px/beat, 20-beat line) in checkerboard mode with 4-pixel squares.
module tb_axi4_video_pattern_gen_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, tready_a, tvalid_a, tlast_a, tuser_a;
  logic [1:0]  pattern_a;
  logic [23:0] solid_a;
  logic [47:0] tdata_a;

  logic        rst_b, tready_b, tvalid_b, tlast_b, tuser_b;
  logic [1:0]  pattern_b;
  logic [23:0] solid_b;
  logic [23:0] tdata_b;

  axi4_video_pattern_gen_mp #(
    .Y_ACTIVE  (4),
    .Y_BLANKING(2),
    .X_ACTIVE  (16),
    .X_BLANKING(4),
    .PX_WIDTH  (8),
    .PX_PER_CLK(2),
    .CHECK_LOG2(6)
  ) u_dut_a (
    .clk_i         (clk),
    .rst_i         (rst_a),
    .pattern_i     (pattern_a),
    .solid_i       (solid_a),
    .video_o_tdata (tdata_a),
    .video_o_tvalid(tvalid_a),
    .video_o_tready(tready_a),
    .video_o_tlast (tlast_a),
    .video_o_tuser (tuser_a)
  );

  axi4_video_pattern_gen_mp #(
    .Y_ACTIVE  (8),
    .Y_BLANKING(1),
    .X_ACTIVE  (16),
    .X_BLANKING(4),
    .PX_WIDTH  (8),
    .PX_PER_CLK(1),
    .CHECK_LOG2(2)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_i         (rst_b),
    .pattern_i     (pattern_b),
    .solid_i       (solid_b),
    .video_o_tdata (tdata_b),
    .video_o_tvalid(tvalid_b),
    .video_o_tready(tready_b),
    .video_o_tlast (tlast_b),
    .video_o_tuser (tuser_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int stab_err = 0;

  logic [47:0] q_data[$];
  logic        q_last[$];
  logic        q_user[$];
  int          q_clk[$];
  logic [23:0] bar_col[8];
  logic [15:0] chk_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic reset_a(input logic [1:0] pat);
    @(negedge clk);
    rst_a     = 1'b1;
    pattern_a = pat;
    tready_a  = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  // Watch DUT A for n_clk negedges or until max_hs handshakes; records accepted beats
  // and counts any output change while a beat is held off by tready.
  task automatic collect(input int n_clk, input int max_hs, input bit rnd);
    logic [50:0] prev;
    bit          prev_stall;
    prev       = '0;
    prev_stall = 1'b0;
    q_data.delete();
    q_last.delete();
    q_user.delete();
    q_clk.delete();
    for (int i = 0; i < n_clk && q_data.size() < max_hs; i++) begin
      @(negedge clk);
      if (prev_stall && ({tvalid_a, tuser_a, tlast_a, tdata_a} !== prev)) stab_err++;
      tready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid_a && tready_a) begin
        q_data.push_back(tdata_a);
        q_last.push_back(tlast_a);
        q_user.push_back(tuser_a);
        q_clk.push_back(i);
      end
      prev_stall = tvalid_a && !tready_a;
      prev       = {tvalid_a, tuser_a, tlast_a, tdata_a};
    end
  endtask

  initial begin
    bar_col[0] = 24'hFFFFFF;  bar_col[1] = 24'hFFFF00;
    bar_col[2] = 24'h00FFFF;  bar_col[3] = 24'h00FF00;
    bar_col[4] = 24'hFF00FF;  bar_col[5] = 24'hFF0000;
    bar_col[6] = 24'h0000FF;  bar_col[7] = 24'h000000;
    chk_mask   = 16'hF0F0;

    rst_a = 1'b1; pattern_a = 2'd0; solid_a = 24'h123456; tready_a = 1'b1;
    rst_b = 1'b1; pattern_b = 2'd2; solid_b = 24'h000000; tready_b = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_tvalid", 64'(tvalid_a), 64'd0);
    check("rst_tdata",  64'(tdata_a),  64'd0);
    check("rst_tlast",  64'(tlast_a),  64'd0);
    check("rst_tuser",  64'(tuser_a),  64'd0);

    // Colour bars, tready always high: 8 beats per 12-clock line, 32 beats per frame.
    rst_a = 1'b0;
    collect(72, 1000, 1'b0);
    check("bars_hs_count", 64'(q_data.size()), 64'd32);
    for (int i = 0; i < 32 && i < q_data.size(); i++)
      check($sformatf("bars_beat%0d", i), 64'({q_user[i], q_last[i], q_data[i]}),
            64'({(i == 0), ((i % 8) == 7), bar_col[i % 8], bar_col[i % 8]}));
    if (q_clk.size() >= 9) begin
      check("bars_first_clk", 64'(q_clk[0]), 64'd0);
      check("bars_b2b",       64'(q_clk[7]), 64'd7);
      check("bars_line_per",  64'(q_clk[8]), 64'd12);
    end

    // Random backpressure on the following frame: same 32 beats, nothing lost or repeated.
    collect(1000, 32, 1'b1);
    check("rnd_hs_count", 64'(q_data.size()), 64'd32);
    check("rnd_stable",   64'(stab_err),      64'd0);
    for (int i = 0; i < q_data.size(); i++)
      check($sformatf("rnd_beat%0d", i), 64'({q_user[i], q_last[i], q_data[i]}),
            64'({(i == 0), ((i % 8) == 7), bar_col[i % 8], bar_col[i % 8]}));
    tready_a = 1'b1;

    // Moving ramp: pixel = px + frame number.
    reset_a(2'd1);
    collect(216, 1000, 1'b0);
    check("ramp_hs_count", 64'(q_data.size()), 64'd96);
    if (q_data.size() == 96) begin
      check("ramp_f0_b0",  64'(q_data[0]),  64'h010101_000000);
      check("ramp_f0_l3e", 64'(q_data[31]), 64'h0F0F0F_0E0E0E);
      check("ramp_f1_b7",  64'(q_data[39]), 64'h101010_0F0F0F);
      check("ramp_f2_b0",  64'(q_data[64]), 64'h030303_020202);
      check("ramp_f2_sof", 64'(q_user[64]), 64'd1);
    end
    repeat (252 * 72 + 1) @(negedge clk);
    check("ramp_f255_b0", 64'({tvalid_a, tuser_a, tdata_a}), 64'({2'b11, 48'h000000_FFFFFF}));
    repeat (72) @(negedge clk);
    check("ramp_f256_b0", 64'({tvalid_a, tuser_a, tdata_a}), 64'({2'b11, 48'h010101_000000}));

    // Pattern change mid-frame only takes effect at the next SOF.
    reset_a(2'd0);
    collect(36, 1000, 1'b0);
    check("chg_first_half", 64'(q_data.size()), 64'd24);
    pattern_a = 2'd3;
    collect(36, 1000, 1'b0);
    check("chg_line3_count", 64'(q_data.size()), 64'd8);
    for (int i = 0; i < q_data.size(); i++)
      check($sformatf("chg_line3_b%0d", i), 64'(q_data[i]), 64'({bar_col[i], bar_col[i]}));
    collect(72, 1000, 1'b0);
    check("solid_hs_count", 64'(q_data.size()), 64'd32);
    if (q_data.size() == 32) begin
      check("solid_sof", 64'(q_user[0]), 64'd1);
      for (int i = 0; i < 32; i += 5)
        check($sformatf("solid_b%0d", i), 64'(q_data[i]), 64'h123456_123456);
    end

    // One-clock reset in the middle of line 0.
    pattern_a = 2'd0;
    reset_a(2'd0);
    collect(3, 1000, 1'b0);
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_tvalid", 64'(tvalid_a), 64'd0);
    check("mid_rst_tdata",  64'(tdata_a),  64'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("mid_rst_sof", 64'({tvalid_a, tuser_a, tdata_a}), 64'({2'b11, 48'hFFFFFF_FFFFFF}));

    // Checkerboard on DUT B: line 0 black/white in 4-pixel runs, line 4 inverted.
    rst_b = 1'b0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (i < 16)
        check($sformatf("chk_l0_p%0d", i), 64'({tvalid_b, tdata_b}),
              64'({1'b1, {24{chk_mask[i]}}}));
      if (i >= 80)
        check($sformatf("chk_l4_p%0d", i - 80), 64'({tvalid_b, tdata_b}),
              64'({1'b1, {24{~chk_mask[i-80]}}}));
      if (i == 0)  check("chk_sof",  64'(tuser_b), 64'd1);
      if (i == 15) check("chk_eol",  64'(tlast_b), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_video_pattern_gen_mp.md
# axi4_video_pattern_gen_mp

Multi-pattern, multi-pixel-per-clock AXI4-Stream video test source with backpressure support. Produces RGB frames of programmable active and blanking size, selects one of four patterns per frame, and animates the ramp pattern frame to frame. Sits at the head of the video pipeline as a drop-in stimulus source for downstream scalers, framebuffers and DMA writers that may stall.

## Interface
- Y_ACTIVE, 1080, active lines per frame
- Y_BLANKING, 45, blanking lines per frame
- X_ACTIVE, 1920, active pixels per line; multiple of 8*PX_PER_CLK
- X_BLANKING, 280, blanking clocks per line (in beats, not pixels)
- PX_WIDTH, 8, bits per colour component
- PX_PER_CLK, 1, pixels per beat (1, 2 or 4)
- CHECK_LOG2, 6, checkerboard square side = 2^CHECK_LOG2 pixels
- TDATA_WIDTH, derived: 3*PX_WIDTH*PX_PER_CLK rounded up to a multiple of 8
- clk_i  in  1  clock; one clock; reset is synchronous and active-high
- rst_i  in  1  synchronous active-high reset
- pattern_i  in  2  pattern select: 0 colour bars, 1 moving ramp, 2 checkerboard, 3 solid
- solid_i  in  3*PX_WIDTH  solid colour {R,G,B}
- video_o_tdata  out  TDATA_WIDTH  pixel data
- video_o_tvalid  out  1  beat valid
- video_o_tready  in  1  sink ready
- video_o_tlast  out  1  last beat of an active line
- video_o_tuser  out  1  first beat of a frame (SOF)

## Operation
- Beat counter x: 0..XB-1, where XB = X_ACTIVE/PX_PER_CLK + X_BLANKING. Line counter y: 0..Y_ACTIVE+Y_BLANKING-1.
- Active beat: x < X_ACTIVE/PX_PER_CLK and y < Y_ACTIVE. Only active beats assert tvalid.
- Counters advance every clock, except that an active beat holds until tvalid && tready. Blanking always elapses at full rate; stalls stretch the line, never shorten blanking.
- tuser = 1 only on beat (x=0, y=0). tlast = 1 only on x = X_ACTIVE/PX_PER_CLK-1 with y < Y_ACTIVE.
- Pixel index px = x*PX_PER_CLK + p, with p = 0..PX_PER_CLK-1. Pixel p is in tdata[p*3*PX_WIDTH +: 3*PX_WIDTH]; within a pixel the order is {R,G,B} with B at the LSBs. Pad bits are 0.
- pattern_i and solid_i are sampled into the frame registers on the clock where the counters wrap to (0,0), and at reset release. Mid-frame changes have no effect until the next frame.
- Pattern 0, colour bars: bar = px / (X_ACTIVE/8). The sequence is white, yellow, cyan, green, magenta, red, blue, black. Each component is either 0 or MAX = 2^PX_WIDTH-1.
- Pattern 1, ramp: R = G = B = (px + frame_cnt) mod 2^PX_WIDTH.
- Pattern 2, checkerboard: the pixel is white (MAX) when px[CHECK_LOG2] XOR y[CHECK_LOG2] is 1, otherwise black.
- Pattern 3, solid: every pixel = latched solid_i.
- frame_cnt is PX_WIDTH bits and increments, with natural wrap, on the counter wrap to (0,0).

## Timing
- All outputs are registered.
- Reset values: tvalid=0, tdata=0, tlast=0, tuser=0; x=0, y=0, frame_cnt=0; frame pattern=0.
- The first beat (SOF, pixel 0) is valid on the first clock after rst_i deasserts.
- Once tvalid=1, tdata, tlast and tuser are held stable until the tready handshake.
- Back-to-back handshakes with tready held at 1 give one beat per clock across the active line.
- Reset mid-frame: outputs drop to their reset values on the next edge with no partial-line completion. The next frame restarts at SOF.
- tready is ignored during blanking. A permanently low tready freezes the generator on the current active beat indefinitely.

## Structure
- Package axi4_video_pattern_gen_pkg holds: the pattern_t enum (COLOR_BARS, RAMP, CHECKER, SOLID), the 8-entry colour-bar RGB constant table normalised to 1-bit per component, and the TDATA_WIDTH derivation function.
- Sub-module video_timing_cnt: the x/y counters with a stall input, producing active, sof, eol and frame_wrap. The top module adds pattern latching, pixel generation, frame_cnt and the output register.

## Test plan
- Params X_ACTIVE=16, X_BLANKING=4, Y_ACTIVE=4, Y_BLANKING=2, PX_PER_CLK=2, PX_WIDTH=8; pattern_i=0; tready=1 -> 8 valid beats per line at 12-clock period. tuser only on the first beat. tlast on beat 7. Beat 0 = {FF,FF,FF} twice; beat 7 = {00,00,00} twice.
- Same params, pattern_i=1 over 3 frames -> frame 0 line 0 beat 0 = pixels 0,1; frame 2 beat 0 = pixels 2,3 (R=G=B). 2 is passed to 3 in frame 2; frame_cnt wraps 255->0.
- Random tready at 50% -> no beat lost or duplicated: exactly 32 handshakes per frame with identical data to the tready=1 run. tdata is stable while tvalid && !tready.
- Change pattern_i 0->3 at mid-frame with solid_i=0x123456 -> the rest of the frame is still bars. The next SOF beat and all beats after it equal 0x123456 per pixel.
- Assert rst_i for 1 clock mid-line -> tvalid=0 the next clock. The following clock gives tuser=1 with pixel 0 of pattern 0.
- PX_PER_CLK=1, CHECK_LOG2=2, X_ACTIVE=16, pattern 2 -> line 0 pixels 0-3 black, 4-7 white. Line 4 is inverted.
